// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl
// Turns N debounced button levels into a stream of press / release /
// long-press / auto-repeat events on one shared valid/ready channel.
// Each button has a hold-time FSM and a one-entry pending slot. A
// round-robin arbiter moves pending events into a registered output stage.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   i_btn        debounced button levels, 1 = pressed
//   o_evt_valid  event available
//   i_evt_ready  consumer accepts the event
//   o_evt_id     button index of the event
//   o_evt_type   00 press, 01 release, 10 long, 11 repeat
//   o_ovf        sticky per-button event-lost flags
//   i_ovf_clr    one-cycle pulse that clears o_ovf
module btn_event_ctrl #(
  parameter int N_BTN     = 4,
  parameter int FREQ      = 25,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  localparam int IDW      = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic             o_evt_valid,
  input  logic             i_evt_ready,
  output logic [IDW-1:0]   o_evt_id,
  output logic [1:0]       o_evt_type,
  output logic [N_BTN-1:0] o_ovf,
  input  logic             i_ovf_clr
);

  localparam int PRE_CNT = FREQ * 1000;
  localparam int PW      = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;
  localparam int HMAX    = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int HW      = $clog2(HMAX + 1);

  localparam logic [PW-1:0]  PRE_MAX = PW'(PRE_CNT - 1);
  localparam logic [HW-1:0]  LONG_V  = HW'(LONG_MS);
  localparam logic [HW-1:0]  REP_V   = HW'(REPEAT_MS);
  localparam logic [IDW-1:0] ID_LAST = IDW'(N_BTN - 1);

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_HELD    = 2'b10
  } state_e;

  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_s;
  logic [N_BTN-1:0] btn_q, btn_d;
  logic [N_BTN-1:0] rise_s, fall_s;

  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [HW-1:0]    hcnt_q  [N_BTN];
  logic [HW-1:0]    hcnt_d  [N_BTN];
  logic [N_BTN-1:0] raise_s;
  logic [1:0]       rtype_s [N_BTN];

  logic [N_BTN-1:0] pend_v_q, pend_v_d;
  logic [1:0]       pend_t_q [N_BTN];
  logic [1:0]       pend_t_d [N_BTN];
  logic [N_BTN-1:0] ovf_q, ovf_d, ovf_set_s;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [1:0]       type_q, type_d;

  logic             load_s, found_s;
  logic [IDW-1:0]   gnt_s;
  logic [N_BTN-1:0] gnt_oh_s;

  // 1 ms prescaler and button edge detection
  always_comb begin
    tick_s = (pre_q == PRE_MAX);
    if (tick_s) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
    btn_d  = i_btn;
    rise_s = i_btn & ~btn_q;
    fall_s = ~i_btn & btn_q;
  end

  // Per-button hold-time FSMs; release takes priority over long/repeat
  always_comb begin
    logic [HW-1:0] h1;
    h1      = '0;
    state_d = state_q;
    hcnt_d  = hcnt_q;
    raise_s = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rtype_s[i] = EV_PRESS;
      h1 = hcnt_q[i] + 1'b1;
      case (state_q[i])
        ST_IDLE: begin
          if (rise_s[i]) begin
            raise_s[i] = 1'b1;
            rtype_s[i] = EV_PRESS;
            hcnt_d[i]  = '0;
            state_d[i] = ST_PRESSED;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (fall_s[i]) begin
            raise_s[i] = 1'b1;
            rtype_s[i] = EV_RELEASE;
            state_d[i] = ST_IDLE;
          end else if (tick_s) begin
            if (h1 == LONG_V) begin
              raise_s[i] = 1'b1;
              rtype_s[i] = EV_LONG;
              hcnt_d[i]  = '0;
              state_d[i] = ST_HELD;
            end else begin
              hcnt_d[i] = h1;
            end
          end else begin
            state_d[i] = ST_PRESSED;
          end
        end
        ST_HELD: begin
          if (fall_s[i]) begin
            raise_s[i] = 1'b1;
            rtype_s[i] = EV_RELEASE;
            state_d[i] = ST_IDLE;
          end else if (tick_s) begin
            // With repeat disabled the counter just wraps; it is never compared.
            if ((REPEAT_MS != 0) && (h1 == REP_V)) begin
              raise_s[i] = 1'b1;
              rtype_s[i] = EV_REPEAT;
              hcnt_d[i]  = '0;
            end else begin
              hcnt_d[i] = h1;
            end
          end else begin
            state_d[i] = ST_HELD;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          hcnt_d[i]  = '0;
        end
      endcase
    end
  end

  // Round-robin search from ptr upward with wrap, and output-stage load
  always_comb begin
    int idx;
    idx     = 0;
    load_s  = !valid_q || i_evt_ready;
    found_s = 1'b0;
    gnt_s   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = (int'(ptr_q) + k) % N_BTN;
      if (!found_s && pend_v_q[idx]) begin
        found_s = 1'b1;
        gnt_s   = IDW'(idx);
      end else begin
      end
    end
    gnt_oh_s = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (load_s && found_s && (gnt_s == IDW'(i))) begin
        gnt_oh_s[i] = 1'b1;
      end else begin
        gnt_oh_s[i] = 1'b0;
      end
    end
    valid_d = valid_q;
    id_d    = id_q;
    type_d  = type_q;
    ptr_d   = ptr_q;
    if (load_s) begin
      valid_d = found_s;
      if (found_s) begin
        id_d   = gnt_s;
        type_d = pend_t_q[gnt_s];
        if (gnt_s == ID_LAST) begin
          ptr_d = '0;
        end else begin
          ptr_d = gnt_s + 1'b1;
        end
      end else begin
      end
    end else begin
    end
  end

  // Pending slots: a slot being granted this edge may take a new event
  always_comb begin
    pend_v_d  = pend_v_q & ~gnt_oh_s;
    pend_t_d  = pend_t_q;
    ovf_set_s = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (raise_s[i]) begin
        if (!pend_v_q[i] || gnt_oh_s[i]) begin
          pend_v_d[i] = 1'b1;
          pend_t_d[i] = rtype_s[i];
        end else begin
          ovf_set_s[i] = 1'b1;
        end
      end else begin
      end
    end
    // A new overflow in the same cycle as a clear survives the clear.
    if (i_ovf_clr) begin
      ovf_d = ovf_set_s;
    end else begin
      ovf_d = ovf_q | ovf_set_s;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      btn_q    <= '0;
      pend_v_q <= '0;
      ovf_q    <= '0;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      type_q   <= 2'b00;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]  <= ST_IDLE;
        hcnt_q[i]   <= '0;
        pend_t_q[i] <= 2'b00;
      end
    end else begin
      pre_q    <= pre_d;
      btn_q    <= btn_d;
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      pend_v_q <= pend_v_d;
      pend_t_q <= pend_t_d;
      ovf_q    <= ovf_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
      type_q   <= type_d;
    end
  end

  assign o_evt_valid = valid_q;
  assign o_evt_id    = id_q;
  assign o_evt_type  = type_q;
  assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed testbench for btn_event_ctrl with FREQ=1, LONG_MS=5, REPEAT_MS=2,
// N_BTN=4 (one tick every 1000 cycles). A monitor logs every transfer with
// the index of the clock edge on which it happened; each test task drives
// stimulus at negedges and compares against hand-derived expectations.
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] i_btn = 4'b0000;
  logic       i_evt_ready = 1'b0;
  logic       i_ovf_clr = 1'b0;
  logic       o_evt_valid;
  logic [1:0] o_evt_id;
  logic [1:0] o_evt_type;
  logic [3:0] o_ovf;

  typedef struct {
    int cyc;
    int id;
    int typ;
  } xfer_t;

  xfer_t q[$];
  int    cyc;
  int    checks = 0;
  int    failures = 0;

  btn_event_ctrl #(
    .N_BTN(4), .FREQ(1), .LONG_MS(5), .REPEAT_MS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn),
    .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready),
    .o_evt_id(o_evt_id), .o_evt_type(o_evt_type),
    .o_ovf(o_ovf), .i_ovf_clr(i_ovf_clr)
  );

  always #5 clk = ~clk;

  // Edge counter since reset release, and transfer log
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (o_evt_valid && i_evt_ready)
        q.push_back('{cyc + 1, int'(o_evt_id), int'(o_evt_type)});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align_phase500();
    while (cyc % 1000 != 500) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #20;
    checks++; if (o_evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_evt_valid); end
    checks++; if (o_evt_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", o_evt_id); end
    checks++; if (o_evt_type !== 2'd0) begin failures++; $display("FAIL reset_type got=%0d exp=0", o_evt_type); end
    checks++; if (o_ovf !== 4'b0000) begin failures++; $display("FAIL reset_ovf got=%b exp=0000", o_ovf); end
    @(negedge clk) rst_n = 1'b1;
    step(5);
    checks++; if (o_evt_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b exp=0", o_evt_valid); end
    checks++; if (o_ovf !== 4'b0000) begin failures++; $display("FAIL post_reset_ovf got=%b exp=0000", o_ovf); end
  endtask

  task automatic test_round_robin();
    int e;
    int exp2[4] = '{2, 3, 0, 1};
    i_evt_ready = 1'b1;
    q.delete();
    e = cyc;
    i_btn = 4'b1111;
    step(10);
    checks++; if (q.size() != 4) begin failures++; $display("FAIL rr1_count got=%0d exp=4", q.size()); end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      checks++; if (q[i].id != i || q[i].cyc != e + 3 + i || q[i].typ != 0) begin
        failures++; $display("FAIL rr1_entry%0d got=id%0d/cyc%0d/t%0d exp=id%0d/cyc%0d/t0", i, q[i].id, q[i].cyc, q[i].typ, i, e + 3 + i);
      end
    end
    i_btn = 4'b0000;
    step(10);
    i_btn = 4'b0010;
    step(10);
    i_btn = 4'b0000;
    step(10);
    q.delete();
    e = cyc;
    i_btn = 4'b1111;
    step(10);
    checks++; if (q.size() != 4) begin failures++; $display("FAIL rr2_count got=%0d exp=4", q.size()); end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      checks++; if (q[i].id != exp2[i] || q[i].cyc != e + 3 + i) begin
        failures++; $display("FAIL rr2_entry%0d got=id%0d/cyc%0d exp=id%0d/cyc%0d", i, q[i].id, q[i].cyc, exp2[i], e + 3 + i);
      end
    end
    i_btn = 4'b0000;
    step(10);
  endtask

  task automatic test_short_press();
    int e;
    i_evt_ready = 1'b1;
    q.delete();
    e = cyc;
    i_btn[2] = 1'b1;
    step(2);
    checks++; if (o_evt_valid !== 1'b1 || o_evt_id !== 2'd2 || o_evt_type !== 2'b00) begin
      failures++; $display("FAIL short_press_out got=v%b/id%0d/t%0d exp=v1/id2/t0", o_evt_valid, o_evt_id, o_evt_type);
    end
    step(2998);
    i_btn[2] = 1'b0;
    step(2);
    checks++; if (o_evt_valid !== 1'b1 || o_evt_id !== 2'd2 || o_evt_type !== 2'b01) begin
      failures++; $display("FAIL short_release_out got=v%b/id%0d/t%0d exp=v1/id2/t1", o_evt_valid, o_evt_id, o_evt_type);
    end
    step(10);
    checks++; if (q.size() != 2) begin failures++; $display("FAIL short_count got=%0d exp=2", q.size()); end
    if (q.size() >= 2) begin
      checks++; if (q[0].cyc != e + 3 || q[0].typ != 0 || q[0].id != 2) begin
        failures++; $display("FAIL short_ev0 got=cyc%0d/t%0d exp=cyc%0d/t0", q[0].cyc, q[0].typ, e + 3);
      end
      checks++; if (q[1].cyc != e + 3003 || q[1].typ != 1 || q[1].id != 2) begin
        failures++; $display("FAIL short_ev1 got=cyc%0d/t%0d exp=cyc%0d/t1", q[1].cyc, q[1].typ, e + 3003);
      end
    end
  endtask

  task automatic test_hold();
    int e;
    int off[6] = '{3, 4502, 6502, 8502, 10502, 12003};
    int typ[6] = '{0, 2, 3, 3, 3, 1};
    i_evt_ready = 1'b1;
    align_phase500();
    q.delete();
    e = cyc;
    i_btn[1] = 1'b1;
    step(12000);
    i_btn[1] = 1'b0;
    step(10);
    checks++; if (q.size() != 6) begin failures++; $display("FAIL hold_count got=%0d exp=6", q.size()); end
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      checks++; if (q[i].id != 1 || q[i].typ != typ[i] || q[i].cyc != e + off[i]) begin
        failures++; $display("FAIL hold_ev%0d got=id%0d/t%0d/cyc%0d exp=id1/t%0d/cyc%0d", i, q[i].id, q[i].typ, q[i].cyc, typ[i], e + off[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    i_evt_ready = 1'b0;
    q.delete();
    i_btn[0] = 1'b1;
    step(2);
    checks++; if (o_evt_valid !== 1'b1 || o_evt_id !== 2'd0 || o_evt_type !== 2'b00) begin
      failures++; $display("FAIL bp_first got=v%b/id%0d/t%0d exp=v1/id0/t0", o_evt_valid, o_evt_id, o_evt_type);
    end
    step(3);
    i_btn[0] = 1'b0;
    step(5);
    i_btn[0] = 1'b1;
    step(3);
    checks++; if (o_evt_valid !== 1'b1 || o_evt_id !== 2'd0 || o_evt_type !== 2'b00) begin
      failures++; $display("FAIL bp_stable got=v%b/id%0d/t%0d exp=v1/id0/t0", o_evt_valid, o_evt_id, o_evt_type);
    end
    checks++; if (o_ovf !== 4'b0001) begin failures++; $display("FAIL bp_ovf_set got=%b exp=0001", o_ovf); end
    i_evt_ready = 1'b1;
    step(5);
    checks++; if (q.size() != 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", q.size()); end
    if (q.size() >= 2) begin
      checks++; if (q[0].typ != 0 || q[1].typ != 1 || q[0].id != 0 || q[1].id != 0 || q[1].cyc != q[0].cyc + 1) begin
        failures++; $display("FAIL bp_order got=t%0d,t%0d cyc%0d,%0d exp=t0,t1 consecutive", q[0].typ, q[1].typ, q[0].cyc, q[1].cyc);
      end
    end
    checks++; if (o_evt_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", o_evt_valid); end
    checks++; if (o_ovf !== 4'b0001) begin failures++; $display("FAIL bp_ovf_sticky got=%b exp=0001", o_ovf); end
    i_btn[0] = 1'b0;
    step(5);
    i_ovf_clr = 1'b1;
    step(1);
    i_ovf_clr = 1'b0;
    checks++; if (o_ovf !== 4'b0000) begin failures++; $display("FAIL bp_ovf_clr got=%b exp=0000", o_ovf); end
    step(5);
  endtask

  task automatic test_simultaneous();
    int e;
    i_evt_ready = 1'b1;
    align_phase500();
    q.delete();
    e = cyc;
    i_btn[3] = 1'b1;
    step(4499);
    i_btn[3] = 1'b0;
    step(3000);
    checks++; if (q.size() != 2) begin failures++; $display("FAIL sim_count got=%0d exp=2", q.size()); end
    if (q.size() >= 2) begin
      checks++; if (q[1].typ != 1 || q[1].id != 3 || q[1].cyc != e + 4502) begin
        failures++; $display("FAIL sim_release got=t%0d/id%0d/cyc%0d exp=t1/id3/cyc%0d", q[1].typ, q[1].id, q[1].cyc, e + 4502);
      end
    end
    // Back in IDLE: a new rise must produce a press.
    q.delete();
    i_btn[3] = 1'b1;
    step(5);
    i_btn[3] = 1'b0;
    step(5);
    checks++; if (q.size() != 2 || q[0].typ != 0 || q[1].typ != 1) begin
      failures++; $display("FAIL sim_idle got=n%0d exp=n2 press,release", q.size());
    end
  endtask

  task automatic test_reset_mid_hold();
    i_evt_ready = 1'b0;
    align_phase500();
    i_btn[0] = 1'b1;
    step(7000);
    checks++; if (o_evt_valid !== 1'b1 || o_ovf !== 4'b0001) begin
      failures++; $display("FAIL rmh_before got=v%b/ovf%b exp=v1/ovf0001", o_evt_valid, o_ovf);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_evt_valid !== 1'b0 || o_evt_id !== 2'd0 || o_evt_type !== 2'd0 || o_ovf !== 4'b0000) begin
      failures++; $display("FAIL rmh_async got=v%b/id%0d/t%0d/ovf%b exp=all0", o_evt_valid, o_evt_id, o_evt_type, o_ovf);
    end
    i_evt_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    step(1);
    checks++; if (o_evt_valid !== 1'b0) begin failures++; $display("FAIL rmh_early got=%b exp=0", o_evt_valid); end
    step(1);
    checks++; if (o_evt_valid !== 1'b1 || o_evt_id !== 2'd0 || o_evt_type !== 2'b00) begin
      failures++; $display("FAIL rmh_press got=v%b/id%0d/t%0d exp=v1/id0/t0", o_evt_valid, o_evt_id, o_evt_type);
    end
    i_btn[0] = 1'b0;
    step(5);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_short_press();
    test_hold();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
